march_bist_seq: RTL and testbench

- Sequences a March C- self-test over one 8-bit-wide SRAM macro.
- Drives the 3-bit BIST mode, the expected read data and the compare-enable to the per-macro 8-bit comparator, and samples that comparator's sticky mismatch flag at the end of every element.
- Sits between the top-level BIST/BISR control and the memory controller datapath.
- Reports pass/fail plus the first failing element to the BISR logic.

---
 rtl/march_bist_seq_pkg.sv | 53 +++++
 rtl/march_bist_seq_if.sv | 36 +++
 rtl/march_rd_pipe.sv | 39 +++
 rtl/march_bist_seq.sv | 150 +++++++++++++++
 tb/tb_march_bist_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/march_bist_seq_pkg.sv
// Shared types for the March C- sequencer: element codes, op types, FSM states
// and the per-element direction/op-count table.
package march_bist_seq_pkg;

    // March element codes, also driven out as bist_mode
    localparam logic [2:0] MODE_W0       = 3'd0;  // up   w0
    localparam logic [2:0] MODE_R0W1_UP  = 3'd1;  // up   r0,w1
    localparam logic [2:0] MODE_R1W0_UP  = 3'd2;  // up   r1,w0
    localparam logic [2:0] MODE_R0W1_DN  = 3'd3;  // down r0,w1
    localparam logic [2:0] MODE_R1W0_DN  = 3'd4;  // down r1,w0
    localparam logic [2:0] MODE_R0_FINAL = 3'd5;  // up   r0

    typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} op_e;

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StCheck, StDone} state_e;

    typedef struct packed {
        logic down;     // address sweep DEPTH-1..0
        logic two_ops;  // read then write at each address
    } elem_t;

    function automatic elem_t elem_info(logic [2:0] mode);
        elem_t e;
        case (mode)
            MODE_R0W1_UP, MODE_R1W0_UP: e = '{down: 1'b0, two_ops: 1'b1};
            MODE_R0W1_DN, MODE_R1W0_DN: e = '{down: 1'b1, two_ops: 1'b1};
            default:                    e = '{down: 1'b0, two_ops: 1'b0};
        endcase
        return e;
    endfunction

    // Operation issued for op slot 'second' of element 'mode'
    function automatic op_e elem_op(logic [2:0] mode, logic second);
        op_e op;
        case (mode)
            MODE_R0W1_UP, MODE_R0W1_DN: op = second ? OP_W1 : OP_R0;
            MODE_R1W0_UP, MODE_R1W0_DN: op = second ? OP_W0 : OP_R1;
            MODE_R0_FINAL:              op = OP_R0;
            default:                    op = OP_W0;
        endcase
        return op;
    endfunction

    function automatic logic op_is_read(op_e op);
        return (op == OP_R0) || (op == OP_R1);
    endfunction

    // Ops whose data is the inverted background
    function automatic logic op_is_one(op_e op);
        return (op == OP_W1) || (op == OP_R1);
    endfunction

endpackage

// File: rtl/march_bist_seq_if.sv
// Bundle between the March sequencer, the BIST control, the memory datapath and
// the per-macro comparator.
interface march_bist_seq_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              bist_start;
    logic              bist_abort;
    logic              bist_en;
    logic [2:0]        bist_mode;
    logic              cmp_en_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        answer;
    logic              cmp_fail;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_fail;
    logic [2:0]        fail_mode;

    // Sequencer side
    modport master (
        input  bist_start, bist_abort, cmp_fail,
        output bist_en, bist_mode, cmp_en_n, mem_addr, mem_wdata, mem_we, mem_re,
               answer, bist_busy, bist_done, bist_fail, fail_mode
    );

    // Control / memory / comparator side
    modport slave (
        output bist_start, bist_abort, cmp_fail,
        input  bist_en, bist_mode, cmp_en_n, mem_addr, mem_wdata, mem_we, mem_re,
               answer, bist_busy, bist_done, bist_fail, fail_mode
    );

endinterface

// File: rtl/march_rd_pipe.sv
// Delays each read's expected data by RD_LAT cycles so it meets the returning
// read data at the comparator. Flush drops everything in flight.
module march_rd_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    output logic       cmp_en_n_o,
    output logic [7:0] answer_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [7:0]        dat_q [RD_LAT];

    // Valid+data shift register, one stage per cycle of read latency
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else if (flush_i) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= push_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign cmp_en_n_o = ~vld_q[RD_LAT-1];
    assign answer_o   = dat_q[RD_LAT-1];

endmodule

// File: rtl/march_bist_seq.sv
// March C- sequencer for one 8-bit SRAM macro: walks the six elements, keeps
// the comparator fed with aligned expected data and records the first failure.
module march_bist_seq
    import march_bist_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned RD_LAT  = 1,
    parameter logic [7:0]  DATA_BG = 8'h00
) (
    input logic              CE,
    input logic              rstn,
    march_bist_seq_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);

    state_e            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              op_q, op_d;        // 0 = first op at this address, 1 = second
    logic [1:0]        drain_q, drain_d;
    logic              fail_q, fail_d;
    logic [2:0]        fail_mode_q, fail_mode_d;

    elem_t      elem;
    op_e        cur_op;
    logic       in_run, rd, wr, last_addr, last_op;
    logic [7:0] op_data;

    // Decode of the current element and op slot
    always_comb begin
        elem      = elem_info(mode_q);
        cur_op    = elem_op(mode_q, op_q);
        in_run    = (state_q == StRun);
        rd        = in_run & op_is_read(cur_op);
        wr        = in_run & ~op_is_read(cur_op);
        op_data   = op_is_one(cur_op) ? ~DATA_BG : DATA_BG;
        last_addr = elem.down ? (addr_q == '0) : (addr_q == ADDR_MAX);
        last_op   = ~elem.two_ops | op_q;
    end

    // Next-state logic; abort overrides everything but keeps the fail record
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        op_d        = op_q;
        drain_d     = drain_q;
        fail_d      = fail_q;
        fail_mode_d = fail_mode_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.bist_start) begin
                    state_d     = StRun;
                    mode_d      = MODE_W0;
                    addr_d      = '0;
                    op_d        = 1'b0;
                    fail_d      = 1'b0;
                    fail_mode_d = '0;
                end
            end
            StRun: begin
                if (last_op) begin
                    op_d = 1'b0;
                    if (last_addr) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        addr_d = elem.down ? addr_q - 1'b1 : addr_q + 1'b1;
                    end
                end else begin
                    op_d = 1'b1;
                end
            end
            StDrain: begin
                // RD_LAT+1 cycles: last read reaches the comparator and is latched
                if (drain_q == DRAIN_LAST) state_d = StCheck;
                else                       drain_d = drain_q + 2'd1;
            end
            StCheck: begin
                if (bus.cmp_fail && !fail_q) fail_mode_d = mode_q;
                fail_d = fail_q | bus.cmp_fail;
                if (mode_q == MODE_R0_FINAL) begin
                    state_d = StDone;
                end else begin
                    state_d = StRun;
                    mode_d  = mode_q + 3'd1;
                    addr_d  = elem_info(mode_q + 3'd1).down ? ADDR_MAX : '0;
                    op_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.bist_abort) begin
            state_d     = StIdle;
            mode_d      = MODE_W0;
            addr_d      = '0;
            op_d        = 1'b0;
            drain_d     = '0;
            fail_d      = fail_q;
            fail_mode_d = fail_mode_q;
        end
    end

    // Sequencer state registers
    always_ff @(posedge CE or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            mode_q      <= MODE_W0;
            addr_q      <= '0;
            op_q        <= 1'b0;
            drain_q     <= '0;
            fail_q      <= 1'b0;
            fail_mode_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            drain_q     <= drain_d;
            fail_q      <= fail_d;
            fail_mode_q <= fail_mode_d;
        end
    end

    march_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i      (CE),
        .rst_ni     (rstn),
        .flush_i    (bus.bist_abort),
        .push_i     (rd),
        .data_i     (rd ? op_data : 8'h00),
        .cmp_en_n_o (bus.cmp_en_n),
        .answer_o   (bus.answer)
    );

    assign bus.bist_en   = (state_q != StIdle);
    assign bus.bist_busy = (state_q == StRun) || (state_q == StDrain) || (state_q == StCheck);
    assign bus.bist_done = (state_q == StDone);
    assign bus.bist_mode = mode_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = wr;
    assign bus.mem_re    = rd;
    assign bus.mem_wdata = wr ? op_data : 8'h00;
    assign bus.bist_fail = fail_q;
    assign bus.fail_mode = fail_mode_q;

endmodule

// File: tb/tb_march_bist_seq.sv
// Directed bench: a 16x8 memory with injectable faults and a sticky comparator
// around an RD_LAT=1 instance, plus a bare RD_LAT=3 instance for alignment.
module tb_march_bist_seq;

    logic CE   = 1'b0;
    logic rstn = 1'b0;

    march_bist_seq_if #(.ADDR_W(4)) bus1 ();
    march_bist_seq_if #(.ADDR_W(4)) bus3 ();

    march_bist_seq #(.ADDR_W(4), .RD_LAT(1), .DATA_BG(8'h00)) dut1 (
        .CE   (CE),
        .rstn (rstn),
        .bus  (bus1)
    );

    march_bist_seq #(.ADDR_W(4), .RD_LAT(3), .DATA_BG(8'h00)) dut3 (
        .CE   (CE),
        .rstn (rstn),
        .bus  (bus3)
    );

    always #5 CE = ~CE;

    int checks = 0;
    int errors = 0;

    // Memory + comparator model for dut1
    logic [7:0] mem [16];
    logic [7:0] rdata     = 8'h00;
    logic       rd_valid  = 1'b0;
    logic       cmp_flag  = 1'b0;
    logic [2:0] mode_prev = 3'd0;
    bit         fault_sa  = 1'b0;  // bit 0 of address 5 stuck at 1
    bit         fault_cf  = 1'b0;  // writing FF to address 4 forces address 3 to FF

    assign bus1.cmp_fail = cmp_flag;
    assign bus3.cmp_fail = 1'b0;

    // Mid-cycle: compare returning data, issue this cycle's op to the array
    always @(negedge CE) begin
        if (!rstn) begin
            cmp_flag  = 1'b0;
            mode_prev = 3'd0;
            rd_valid  = 1'b0;
        end else begin
            if (bus1.bist_mode != mode_prev) begin
                cmp_flag  = 1'b0;
                mode_prev = bus1.bist_mode;
            end
            if (!bus1.cmp_en_n && (!rd_valid || rdata !== bus1.answer)) cmp_flag = 1'b1;
            rd_valid = bus1.mem_re;
            rdata    = mem[bus1.mem_addr];
            if (fault_sa && bus1.mem_addr == 4'd5) rdata[0] = 1'b1;
            if (bus1.mem_we) begin
                mem[bus1.mem_addr] = bus1.mem_wdata;
                if (fault_cf && bus1.mem_addr == 4'd4 && bus1.mem_wdata == 8'hFF)
                    mem[3] = 8'hFF;
            end
        end
    end

    task automatic run_dut1(output int cyc, output int overlap, output int bad_mode,
                            output int steps, output int bad_align);
        logic [2:0] pm;
        logic       pre_re;
        cyc = 0; overlap = 0; bad_mode = 0; steps = 0; bad_align = 0;
        pm = 3'd0; pre_re = 1'b0;
        @(negedge CE);
        bus1.bist_start = 1'b1;
        @(posedge CE);
        #1 bus1.bist_start = 1'b0;
        while (cyc < 1000) begin
            @(negedge CE);
            if (bus1.bist_done) break;
            if (bus1.mem_we && bus1.mem_re) overlap++;
            if (bus1.bist_mode != pm) begin
                steps++;
                if (bus1.bist_mode != pm + 3'd1) bad_mode++;
            end
            pm = bus1.bist_mode;
            if (bus1.cmp_en_n !== !pre_re) bad_align++;
            pre_re = bus1.mem_re;
            @(posedge CE);
            cyc++;
        end
    endtask

    task automatic test_reset;
        bus1.bist_start = 1'b0; bus1.bist_abort = 1'b0;
        bus3.bist_start = 1'b0; bus3.bist_abort = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge CE);
        checks++;
        if ({bus1.bist_en, bus1.bist_busy, bus1.bist_done, bus1.bist_fail} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status: got %b want 0000",
                     {bus1.bist_en, bus1.bist_busy, bus1.bist_done, bus1.bist_fail});
        end
        checks++;
        if ({bus1.bist_mode, bus1.fail_mode, bus1.mem_we, bus1.mem_re, bus1.mem_addr,
             bus1.mem_wdata, bus1.answer, bus1.cmp_en_n} !== 31'h1) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 00000001",
                     {bus1.bist_mode, bus1.fail_mode, bus1.mem_we, bus1.mem_re, bus1.mem_addr,
                      bus1.mem_wdata, bus1.answer, bus1.cmp_en_n});
        end
        rstn = 1'b1;
        repeat (3) @(negedge CE);
        checks++;
        if (bus1.bist_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hold: got bist_en=%b want 0", bus1.bist_en);
        end
    endtask

    task automatic test_fault_free;
        int cyc, ov, bm, st, ba;
        run_dut1(cyc, ov, bm, st, ba);
        checks++;
        if (cyc != 178) begin
            errors++; $display("FAIL ff_cycles: got %0d want 178", cyc);
        end
        checks++;
        if ({bus1.bist_done, bus1.bist_busy, bus1.bist_en} !== 3'b101) begin
            errors++;
            $display("FAIL ff_done_flags: got %b want 101",
                     {bus1.bist_done, bus1.bist_busy, bus1.bist_en});
        end
        checks++;
        if ({bus1.bist_fail, bus1.fail_mode} !== 4'b0000) begin
            errors++;
            $display("FAIL ff_fail: got %b/%0d want 0/0", bus1.bist_fail, bus1.fail_mode);
        end
        checks++;
        if (ov != 0) begin
            errors++; $display("FAIL ff_we_re_overlap: got %0d want 0", ov);
        end
        checks++;
        if (bm != 0 || st != 5 || bus1.bist_mode !== 3'd5) begin
            errors++;
            $display("FAIL ff_mode_steps: got bad=%0d steps=%0d final=%0d want 0 5 5",
                     bm, st, bus1.bist_mode);
        end
        checks++;
        if (ba != 0) begin
            errors++; $display("FAIL ff_cmp_align: got %0d misaligned want 0", ba);
        end
    endtask

    task automatic test_stuck_at;
        int cyc, ov, bm, st, ba;
        fault_sa = 1'b1;
        run_dut1(cyc, ov, bm, st, ba);
        fault_sa = 1'b0;
        checks++;
        if (cyc != 178 || bus1.bist_done !== 1'b1) begin
            errors++;
            $display("FAIL sa_completes: got cyc=%0d done=%b want 178 1", cyc, bus1.bist_done);
        end
        checks++;
        if ({bus1.bist_fail, bus1.fail_mode} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL sa_fail_mode: got %b/%0d want 1/1", bus1.bist_fail, bus1.fail_mode);
        end
    endtask

    task automatic test_coupling;
        int cyc, ov, bm, st, ba;
        fault_cf = 1'b1;
        run_dut1(cyc, ov, bm, st, ba);
        fault_cf = 1'b0;
        checks++;
        if (cyc != 178) begin
            errors++; $display("FAIL cf_cycles: got %0d want 178", cyc);
        end
        checks++;
        if ({bus1.bist_fail, bus1.fail_mode} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL cf_fail_mode: got %b/%0d want 1/3", bus1.bist_fail, bus1.fail_mode);
        end
    endtask

    task automatic test_abort;
        int cyc, ov, bm, st, ba;
        int n;
        @(negedge CE);
        bus1.bist_start = 1'b1;
        @(posedge CE);
        #1 bus1.bist_start = 1'b0;
        n = 0;
        while (n < 500) begin
            @(negedge CE);
            if (bus1.bist_mode == 3'd2) break;
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++; $display("FAIL abort_reach_mode2: got timeout want mode 2");
        end
        repeat (5) @(negedge CE);
        bus1.bist_abort = 1'b1;
        @(posedge CE);
        #1 bus1.bist_abort = 1'b0;
        @(negedge CE);
        checks++;
        if ({bus1.bist_en, bus1.bist_busy, bus1.bist_done, bus1.mem_we, bus1.mem_re,
             bus1.cmp_en_n} !== 6'b000001) begin
            errors++;
            $display("FAIL abort_idle: got %b want 000001",
                     {bus1.bist_en, bus1.bist_busy, bus1.bist_done, bus1.mem_we, bus1.mem_re,
                      bus1.cmp_en_n});
        end
        // Abort and start together: abort wins
        bus1.bist_start = 1'b1;
        bus1.bist_abort = 1'b1;
        @(posedge CE);
        #1;
        bus1.bist_start = 1'b0;
        bus1.bist_abort = 1'b0;
        @(negedge CE);
        checks++;
        if (bus1.bist_en !== 1'b0) begin
            errors++; $display("FAIL abort_beats_start: got bist_en=%b want 0", bus1.bist_en);
        end
        run_dut1(cyc, ov, bm, st, ba);
        checks++;
        if (cyc != 178 || st != 5 || bus1.bist_fail !== 1'b0) begin
            errors++;
            $display("FAIL abort_rerun: got cyc=%0d steps=%0d fail=%b want 178 5 0",
                     cyc, st, bus1.bist_fail);
        end
    endtask

    task automatic test_rd_lat3;
        int         cyc;
        int         bad_align;
        int         e2;
        int         bad_ans;
        logic [2:0] hist;
        cyc = 0; bad_align = 0; e2 = 0; bad_ans = 0; hist = 3'b000;
        @(negedge CE);
        bus3.bist_start = 1'b1;
        @(posedge CE);
        #1 bus3.bist_start = 1'b0;
        while (cyc < 1000) begin
            @(negedge CE);
            if (bus3.bist_done) break;
            if (bus3.cmp_en_n !== !hist[2]) bad_align++;
            if (!bus3.cmp_en_n && bus3.bist_mode == 3'd2) begin
                e2++;
                if (bus3.answer !== 8'hFF) bad_ans++;
            end
            hist = {hist[1:0], bus3.mem_re};
            @(posedge CE);
            cyc++;
        end
        checks++;
        if (cyc != 190) begin
            errors++; $display("FAIL lat3_cycles: got %0d want 190", cyc);
        end
        checks++;
        if (bad_align != 0) begin
            errors++; $display("FAIL lat3_cmp_align: got %0d misaligned want 0", bad_align);
        end
        checks++;
        if (e2 != 16 || bad_ans != 0) begin
            errors++;
            $display("FAIL lat3_answer_e2: got reads=%0d bad=%0d want 16 0", e2, bad_ans);
        end
        checks++;
        if ({bus3.bist_fail, bus3.fail_mode} !== 4'b0000) begin
            errors++;
            $display("FAIL lat3_fail: got %b/%0d want 0/0", bus3.bist_fail, bus3.fail_mode);
        end
    endtask

    task automatic test_reset_in_drain;
        int n;
        fault_sa = 1'b1;  // so bist_fail is set before the reset hits
        @(negedge CE);
        bus1.bist_start = 1'b1;
        @(posedge CE);
        #1 bus1.bist_start = 1'b0;
        n = 0;
        while (n < 500) begin
            @(negedge CE);
            if (bus1.bist_mode == 3'd4 && bus1.bist_busy && !bus1.mem_re && !bus1.mem_we) break;
            n++;
        end
        fault_sa = 1'b0;
        checks++;
        if (n >= 500 || bus1.bist_fail !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_drain4: got n=%0d fail=%b want drain with fail=1",
                     n, bus1.bist_fail);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus1.bist_en, bus1.bist_busy, bus1.bist_done, bus1.bist_fail, bus1.bist_mode,
             bus1.fail_mode, bus1.mem_addr, bus1.cmp_en_n} !== 15'h0001) begin
            errors++;
            $display("FAIL rst_drain_outputs: got %h want 0001",
                     {bus1.bist_en, bus1.bist_busy, bus1.bist_done, bus1.bist_fail,
                      bus1.bist_mode, bus1.fail_mode, bus1.mem_addr, bus1.cmp_en_n});
        end
        checks++;
        if (bus3.bist_done !== 1'b0) begin
            errors++; $display("FAIL rst_lat3_done: got %b want 0", bus3.bist_done);
        end
        @(negedge CE);
        rstn = 1'b1;
        repeat (5) @(negedge CE);
        checks++;
        if ({bus1.bist_en, bus1.bist_busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_stays_idle: got %b want 00", {bus1.bist_en, bus1.bist_busy});
        end
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_coupling();
        test_abort();
        test_rd_lat3();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
